// File: rtl/lsu_ctrl_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, bus size
// encodings, response error codes and request decode helpers.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Bus SIZE encoding, which differs from the funct3[1:0] ordering
    typedef enum logic [1:0] {
        SZ_WORD   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_BYTE   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_e;

    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    function automatic size_e decode_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            2'b10:   return SZ_WORD;
            default: return SZ_DOUBLE;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [2:0] addr_lo);
        case (size)
            SZ_HALF:   return addr_lo[0];
            SZ_WORD:   return |addr_lo[1:0];
            SZ_DOUBLE: return |addr_lo;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Combinational lane handling: little-endian load extraction with sign/zero
// extension, and store-data replication across all lanes of the bus.
module lsu_ctrl_align
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [1:0]       i_st_size,
    input  logic [XLEN-1:0]  i_st_data,
    output logic [XLEN-1:0]  o_st_data,
    input  logic [1:0]       i_ld_size,
    input  logic             i_ld_unsigned,
    input  logic [OFF_W-1:0] i_ld_offset,
    input  logic [XLEN-1:0]  i_ld_data,
    output logic [XLEN-1:0]  o_ld_data
);

    logic [XLEN-1:0] w_ld_shift;
    logic            w_ld_fill;
    int              w_ld_bits;

    always_comb begin
        case (size_e'(i_st_size))
            SZ_BYTE: o_st_data = {(XLEN / 8){i_st_data[7:0]}};
            SZ_HALF: o_st_data = {(XLEN / 16){i_st_data[15:0]}};
            SZ_WORD: o_st_data = {(XLEN / 32){i_st_data[31:0]}};
            default: o_st_data = i_st_data;
        endcase
    end

    // The addressed lane is moved down to bit 0 before extension
    assign w_ld_shift = i_ld_data >> {i_ld_offset, 3'b000};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred
        w_ld_bits = XLEN;
        w_ld_fill = 1'b0;
        case (size_e'(i_ld_size))
            SZ_BYTE: begin w_ld_bits = 8;  w_ld_fill = w_ld_shift[7];  end
            SZ_HALF: begin w_ld_bits = 16; w_ld_fill = w_ld_shift[15]; end
            SZ_WORD: begin w_ld_bits = 32; w_ld_fill = w_ld_shift[31]; end
            default: begin w_ld_bits = XLEN; w_ld_fill = w_ld_shift[XLEN-1]; end
        endcase
        w_ld_fill = w_ld_fill & ~i_ld_unsigned;
        for (int i = 0; i < XLEN; i++) begin
            o_ld_data[i] = (i < w_ld_bits) ? w_ld_shift[i] : w_ld_fill;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one request, runs the bus handshake with timeout,
// and returns aligned load data or an error code as a one-cycle response.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_func,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic [1:0]        rsp_err,
    input  logic              ACKD_n,
    output logic [ADDR_W-1:0] DAD,
    output logic              MREQ,
    output logic              WRITE,
    output logic [1:0]        SIZE,
    inout  wire  [XLEN-1:0]   DDT
);

    localparam int OFF_W = $clog2(XLEN / 8);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    size_e             r_size;
    logic              r_write;
    logic              r_unsigned;
    logic [XLEN-1:0]   r_wdata;
    logic [4:0]        r_rd;
    err_e              r_err;
    logic [XLEN-1:0]   r_rdata;
    logic [7:0]        r_cnt;
    logic              r_mreq;

    size_e           w_req_size;
    logic            w_illegal;
    err_e            w_req_err;
    logic            w_ack;
    logic            w_timeout;
    logic [XLEN-1:0] w_st_data;
    logic [XLEN-1:0] w_ld_data;

    assign w_req_size = decode_size(req_func[1:0]);
    assign w_illegal  = (req_func == F3_BAD) || (req_write && req_func[2]) ||
                        (XLEN == 32 && (w_req_size == SZ_DOUBLE || req_func == F3_LWU));
    assign w_req_err  = w_illegal ? ERR_ILLEGAL :
                        is_misaligned(w_req_size, req_addr[2:0]) ? ERR_MISALIGN : ERR_OK;
    assign w_ack      = ~ACKD_n;
    assign w_timeout  = (r_cnt == 8'(TIMEOUT - 1));

    lsu_ctrl_align #(.XLEN(XLEN)) u_align (
        .i_st_size     (w_req_size),
        .i_st_data     (req_wdata),
        .o_st_data     (w_st_data),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_unsigned),
        .i_ld_offset   (r_addr[OFF_W-1:0]),
        .i_ld_data     (DDT),
        .o_ld_data     (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_next = (w_req_err == ERR_OK) ? ST_BUS : ST_RESP;
            ST_BUS:  if (w_ack || w_timeout) w_state_next = ST_RESP;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall     = (r_state == ST_BUS) || (r_state == ST_IDLE && req_valid);
        rsp_valid = (r_state == ST_RESP);
    end

    // Ack is checked before timeout so an ack on the final BUS edge still succeeds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_size     <= SZ_WORD;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_err      <= ERR_OK;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_mreq     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values
            r_mreq <= (w_state_next == ST_BUS);
            if (r_state == ST_IDLE && req_valid) begin
                r_rd    <= req_rd;
                r_err   <= w_req_err;
                r_rdata <= '0;
                r_cnt   <= '0;
                if (w_req_err == ERR_OK) begin
                    r_addr     <= req_addr;
                    r_size     <= w_req_size;
                    r_write    <= req_write;
                    r_unsigned <= req_func[2];
                    r_wdata    <= w_st_data;
                end
            end else if (r_state == ST_BUS) begin
                if (w_ack) begin
                    if (!r_write) r_rdata <= w_ld_data;
                end else if (w_timeout) begin
                    r_err <= ERR_TIMEOUT;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign DAD       = r_addr;
    assign MREQ      = r_mreq;
    assign WRITE     = r_write;
    assign SIZE      = r_size;
    assign rsp_rdata = r_rdata;
    assign rsp_rd    = r_rd;
    assign rsp_err   = r_err;
    assign DDT       = (r_mreq && r_write) ? r_wdata : {XLEN{1'bz}};

endmodule
